aes_block_buffer: RTL and testbench

AES_BLOCK_BUFFER -- requirements
Module: aes_block_buffer

---
 rtl/aes_block_buffer_pkg.sv | 19 +
 rtl/aes_block_buffer.sv | 126 ++++++++++++
 tb/tb_aes_block_buffer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_buffer_pkg.sv
// Shared types and constants for the AES block buffer: FSM state encoding,
// block width and the word byte-swap helper.
package aes_package;

    localparam int AES_BLOCK_BITS = 128;
    localparam int AES_WORD_BITS  = 32;

    typedef enum logic [1:0] {
        FILL,
        BLK_OUT,
        WAIT_RES,
        DRAIN
    } aes_buf_state_t;

    function automatic logic [AES_WORD_BITS-1:0] byte_swap(input logic [AES_WORD_BITS-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_block_buffer.sv
// Packs a word stream into 128-bit AES blocks, hands them to the cipher core
// and unpacks the ciphertext back into words. AES_BLOCK_BUFFER_BYTESWAP_EN byte-reverses words.
module aes_block_buffer
    import aes_package::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      in_valid_i,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    output logic                      in_ready_o,
    output logic                      blk_valid_o,
    output logic [AES_BLOCK_BITS-1:0] blk_data_o,
    input  logic                      blk_ready_i,
    input  logic                      res_valid_i,
    input  logic [AES_BLOCK_BITS-1:0] res_data_i,
    output logic                      res_ready_o,
    output logic                      out_valid_o,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    input  logic                      out_ready_i,
    output logic [15:0]               block_count_o,
    output logic                      busy_o
);

    localparam int IDX_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    // Element 0 of an ascending packed range is the most significant word.
    typedef logic [0:WORDS_PER_BLOCK-1][DATA_WIDTH-1:0] block_t;

    aes_buf_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    block_t           blk_q, blk_d;
    logic [15:0]      count_q, count_d;

    logic [DATA_WIDTH-1:0] in_word;
    logic [DATA_WIDTH-1:0] out_word;

`ifdef AES_BLOCK_BUFFER_BYTESWAP_EN
    assign in_word  = byte_swap(in_data_i);
    assign out_word = byte_swap(blk_q[idx_q]);
`else
    assign in_word  = in_data_i;
    assign out_word = blk_q[idx_q];
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        count_d = count_q;

        unique case (state_q)
            FILL: begin
                if (in_valid_i) begin
                    blk_d[idx_q] = in_word;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = BLK_OUT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            BLK_OUT: begin
                if (blk_ready_i) state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_valid_i) begin
                    blk_d   = res_data_i;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        count_d = count_q + 16'd1;
                        state_d = FILL;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // NOTE: clear is applied last so it overrides any handshake decided above.
        if (clear) begin
            state_d = FILL;
            idx_d   = '0;
            blk_d   = '0;
            count_d = '0;
        end
    end

    // NOTE: blk_q is a plain flop vector, not a RAM, so it is reset along with the
    // rest of the state; reset is synchronous, so only clk appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            blk_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            count_q <= count_d;
        end
    end

    // Every handshake output is a pure decode of registered state.
    assign in_ready_o    = (state_q == FILL);
    assign blk_valid_o   = (state_q == BLK_OUT);
    assign res_ready_o   = (state_q == WAIT_RES);
    assign out_valid_o   = (state_q == DRAIN);
    assign blk_data_o    = blk_q;
    assign out_data_o    = out_word;
    assign block_count_o = count_q;
    assign busy_o        = !((state_q == FILL) && (idx_q == '0));

endmodule

// File: tb/tb_aes_block_buffer.sv
// Directed scoreboard bench for aes_block_buffer; inputs are driven and outputs
// sampled on the falling clock edge.
module tb_aes_block_buffer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         in_valid_i;
    logic [31:0]  in_data_i;
    logic         in_ready_o;
    logic         blk_valid_o;
    logic [127:0] blk_data_o;
    logic         blk_ready_i;
    logic         res_valid_i;
    logic [127:0] res_data_i;
    logic         res_ready_o;
    logic         out_valid_o;
    logic [31:0]  out_data_o;
    logic         out_ready_i;
    logic [15:0]  block_count_o;
    logic         busy_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] exp_blk_q[$];
    logic [31:0]  exp_out_q[$];

    always #5 clk = ~clk;

    aes_block_buffer #(.DATA_WIDTH(32), .WORDS_PER_BLOCK(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .blk_valid_o  (blk_valid_o),
        .blk_data_o   (blk_data_o),
        .blk_ready_i  (blk_ready_i),
        .res_valid_i  (res_valid_i),
        .res_data_i   (res_data_i),
        .res_ready_o  (res_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .block_count_o(block_count_o),
        .busy_o       (busy_o)
    );

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_BLOCK_BUFFER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Four words with in_valid held continuously; the block is expected the cycle after the last one.
    task automatic send_block(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        exp_blk_q.push_back({sw(w0), sw(w1), sw(w2), sw(w3)});
        for (int i = 0; i < 4; i++) begin
            check("in_ready_fill", in_ready_o, 1'b1);
            check("blk_valid_early", blk_valid_o, 1'b0);
            in_valid_i = 1'b1;
            in_data_i  = w[i];
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        check("blk_valid_latency", blk_valid_o, 1'b1);
    endtask

    task automatic take_block();
        int n = 0;
        blk_ready_i = 1'b1;
        while (!blk_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("blk_valid_wait", blk_valid_o, 1'b1);
        check("blk_data", blk_data_o, exp_blk_q.pop_front());
        @(negedge clk);
        blk_ready_i = 1'b0;
        check("blk_valid_dropped", blk_valid_o, 1'b0);
    endtask

    task automatic give_result(input logic [127:0] r);
        int n = 0;
        res_valid_i = 1'b1;
        res_data_i  = r;
        while (!res_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("res_ready_wait", res_ready_o, 1'b1);
        for (int i = 3; i >= 0; i--) exp_out_q.push_back(sw(r[32*i +: 32]));
        @(negedge clk);
        res_valid_i = 1'b0;
        check("res_ready_dropped", res_ready_o, 1'b0);
    endtask

    task automatic drain(input bit toggle);
        int n = 0;
        bit phase = 1'b0;
        bit hs;
        while (exp_out_q.size() != 0 && n < 64) begin
            check("out_valid_hold", out_valid_o, 1'b1);
            check("out_data", out_data_o, exp_out_q[0]);
            out_ready_i = toggle ? phase : 1'b1;
            phase = !phase;
            hs = out_valid_o && out_ready_i;
            @(negedge clk);
            n++;
            if (hs) void'(exp_out_q.pop_front());
        end
        out_ready_i = 1'b0;
        check("drain_done", 128'(exp_out_q.size()), 128'd0);
        check("out_valid_after_drain", out_valid_o, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
        blk_ready_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0; out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("rst_in_ready", in_ready_o, 1'b1);
        check("rst_blk_valid", blk_valid_o, 1'b0);
        check("rst_res_ready", res_ready_o, 1'b0);
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_count", block_count_o, 16'h0000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_blk_data", blk_data_o, 128'h0);

        // Basic block plus blk_ready backpressure with a fifth word pending.
        send_block(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
        check("busy_blk_out", busy_o, 1'b1);
        in_valid_i = 1'b1;
        in_data_i  = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            check("bp_blk_valid", blk_valid_o, 1'b1);
            check("bp_in_ready", in_ready_o, 1'b0);
            check("bp_blk_data", blk_data_o, exp_blk_q[0]);
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        take_block();

        // In WAIT_RES, stray sink/source handshakes must not advance anything.
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        repeat (2) @(negedge clk);
        check("wr_res_ready", res_ready_o, 1'b1);
        check("wr_out_valid", out_valid_o, 1'b0);
        check("wr_in_ready", in_ready_o, 1'b0);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;

        give_result(128'h69C4E0D86A7B0430D8CDB78070B4C55A);
        drain(1'b1);
        check("count_one", block_count_o, 16'h0001);
        check("busy_idle", busy_o, 1'b0);

        // Clear after two words; clear also wins over a simultaneous input word.
        in_valid_i = 1'b1;
        in_data_i  = 32'hAAAA0001;
        @(negedge clk);
        in_data_i  = 32'hAAAA0002;
        @(negedge clk);
        check("busy_mid_fill", busy_o, 1'b1);
        in_data_i  = 32'hAAAA0003;
        clear      = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        in_valid_i = 1'b0;
        check("clr_busy", busy_o, 1'b0);
        check("clr_count", block_count_o, 16'h0000);
        check("clr_blk_data", blk_data_o, 128'h0);
        send_block(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
        check("clr_count_hold", block_count_o, 16'h0000);
        take_block();
        give_result(128'h000102030405060708090A0B0C0D0E0F);
        drain(1'b0);
        check("count_after_clr_block", block_count_o, 16'h0001);

        // Clear mid-drain, together with an output handshake.
        send_block(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        take_block();
        give_result(128'hF0E0D0C0B0A090807060504030201000);
        check("md_out_data0", out_data_o, exp_out_q[0]);
        out_ready_i = 1'b1;
        @(negedge clk);
        void'(exp_out_q.pop_front());
        check("md_out_data1", out_data_o, exp_out_q[0]);
        clear = 1'b1;
        @(negedge clk);
        clear       = 1'b0;
        out_ready_i = 1'b0;
        exp_out_q.delete();
        check("md_out_valid", out_valid_o, 1'b0);
        check("md_in_ready", in_ready_o, 1'b1);
        check("md_count", block_count_o, 16'h0000);
        check("md_busy", busy_o, 1'b0);

        // Counter wrap from 0xFFFF.
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        @(negedge clk);
        check("wrap_preload", block_count_o, 16'hFFFF);
        send_block(32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 32'h9ABCDEF0);
        take_block();
        give_result(128'h0123456789ABCDEFFEDCBA9876543210);
        drain(1'b1);
        check("wrap_zero", block_count_o, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
